// File: rtl/refill_arbiter.sv
// rtl/refill_arbiter.sv - two-requester WRAP4 line-refill arbiter on one AHB-Lite master port
//
// Purpose: arbitrates between an I-cache miss path (req0) and a next-line prefetcher
// (req1), issues one critical-word-first WRAP4 read burst for the winner, assembles the
// 128-bit line and returns it on that requester's response port.
//
// Ports:
//   hclk, hrstn                  clock, asynchronous active-low reset
//   reqN_valid / reqN_addr       refill request and critical-word byte address
//   reqN_ready                   one-cycle grant pulse, address latched on that edge
//   respN_valid / respN_err      one-cycle response pulse, error qualifier
//   respN_line                   assembled line, word w at bits [32w+31:32w]
//   haddr/htrans/hburst/hsize/hwrite   AHB-Lite master address/control (read-only)
//   hrdata/hready/hresp          AHB-Lite read data, transfer done/stall, error
module refill_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BITS  = 128,
    parameter int PRIO_INIT  = 0
) (
    input  logic                  hclk,
    input  logic                  hrstn,
    input  logic                  req0_valid,
    input  logic [31:0]           req0_addr,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic                  resp0_err,
    output logic [LINE_BITS-1:0]  resp0_line,
    input  logic                  req1_valid,
    input  logic [31:0]           req1_addr,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic                  resp1_err,
    output logic [LINE_BITS-1:0]  resp1_line,
    output logic [31:0]           haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_RESP, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic                  owner_q, owner_d;
    logic                  ptr_q, ptr_d;
    logic [1:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic [LINE_BITS-1:0]  buf_q, buf_d;
    logic [LINE_BITS-1:0]  line0_q, line0_d;
    logic [LINE_BITS-1:0]  line1_q, line1_d;

    logic       grant;
    logic       win;
    logic       data_phase;
    logic       err_first;
    logic [1:0] wrap_idx;
    logic [1:0] cap_idx;
    logic       unused_addr_bits;

    // Word offsets [1:0] are never driven on the bus.
    assign unused_addr_bits = ^{req0_addr[1:0], req1_addr[1:0]};

    // Contention goes to the pointer side; a lone requester wins regardless.
    assign win   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    // Gated by reset so no grant can leak out while the block is held in reset.
    assign grant = (state_q == S_IDLE) && (req0_valid || req1_valid) && hrstn;

    assign req0_ready = grant && !win;
    assign req1_ready = grant &&  win;

    // beat_q counts accepted addresses, so the beat whose data is on hrdata
    // now is one behind it (wraps to word A+3 in DRAIN where beat_q is 0).
    assign wrap_idx   = addr_q[3:2] + beat_q;
    assign cap_idx    = addr_q[3:2] + beat_q - 2'd1;
    assign data_phase = (state_q == S_BURST) || (state_q == S_DRAIN);
    assign err_first  = data_phase && hresp && !hready;

    // State register
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_ADDR;
            S_ADDR:  if (hready) state_d = S_BURST;
            S_BURST: begin
                if (err_first) state_d = S_ERR;
                else if (hready && beat_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (err_first) state_d = S_ERR;
                else if (hready) state_d = S_RESP;
            end
            S_ERR:   if (hready) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        htrans      = HTRANS_IDLE;
        haddr       = 32'd0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state_q)
            S_ADDR: begin
                htrans = HTRANS_NONSEQ;
                haddr  = addr_q;
            end
            S_BURST: begin
                htrans = HTRANS_SEQ;
                haddr  = {addr_q[31:4], wrap_idx, 2'b00};
            end
            S_RESP: begin
                resp0_valid = !owner_q;
                resp1_valid =  owner_q;
            end
            default: ;
        endcase
    end

    assign resp0_err  = resp0_valid && err_q;
    assign resp1_err  = resp1_valid && err_q;
    assign resp0_line = line0_q;
    assign resp1_line = line1_q;
    assign hburst     = 3'b010;
    assign hsize      = 3'b010;
    assign hwrite     = 1'b0;

    // Datapath next-state
    always_comb begin
        addr_d  = addr_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        buf_d   = buf_q;
        line0_d = line0_q;
        line1_d = line1_q;
        if (grant) begin
            owner_d = win;
            ptr_d   = !win;
            addr_d  = win ? {req1_addr[31:2], 2'b00} : {req0_addr[31:2], 2'b00};
            err_d   = 1'b0;
            beat_d  = 2'd0;
        end
        if (err_first) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_ADDR:  if (hready) beat_d = 2'd1;
            S_BURST: begin
                if (hready) begin
                    buf_d[cap_idx*DATA_WIDTH +: DATA_WIDTH] = hrdata;
                    beat_d = beat_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (hready) begin
                    buf_d[cap_idx*DATA_WIDTH +: DATA_WIDTH] = hrdata;
                    // Publish only the completed line so each side's output
                    // stays stable until its next response.
                    if (owner_q) line1_d = buf_d;
                    else         line0_d = buf_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            addr_q  <= 32'd0;
            owner_q <= 1'b0;
            ptr_q   <= (PRIO_INIT != 0);
            beat_q  <= 2'd0;
            err_q   <= 1'b0;
            buf_q   <= '0;
            line0_q <= '0;
            line1_q <= '0;
        end else begin
            addr_q  <= addr_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            line0_q <= line0_d;
            line1_q <= line1_d;
        end
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// tb/tb_refill_arbiter.sv - directed self-checking bench for refill_arbiter
module tb_refill_arbiter;

    logic         hclk = 1'b0;
    logic         hrstn;
    logic         req0_valid, req1_valid;
    logic [31:0]  req0_addr, req1_addr;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [127:0] resp0_line, resp1_line;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst, hsize;
    logic         hwrite;
    logic [31:0]  hrdata;
    logic         hready, hresp;
    logic [31:0]  dph_addr;

    int checks = 0;
    int errors = 0;

    refill_arbiter #(.DATA_WIDTH(32), .LINE_BITS(128), .PRIO_INIT(0)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_err(resp0_err), .resp0_line(resp0_line),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_err(resp1_err), .resp1_line(resp1_line),
        .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    // Memory contents: each word derived from its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word({a[31:4], 4'(w * 4)});
        return l;
    endfunction

    // Slave: data phase follows an accepted NONSEQ/SEQ address.
    always @(posedge hclk or negedge hrstn) begin
        if (!hrstn) dph_addr <= 32'd0;
        else if (hready && htrans[1]) dph_addr <= haddr;
    end
    assign hrdata = mem_word(dph_addr);

    task automatic step();
        @(negedge hclk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        hrstn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
        step();
        hrstn = 1'b1;
        step();
    endtask

    // Zero-wait burst starting at the negedge of the grant cycle G; ends at G+6.
    task automatic burst(input bit side, input logic [31:0] a, input bit drop,
                         input logic [31:0] next_a);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        #1;
        check("grant_ready", side ? req1_ready : req0_ready, 1'b1);
        check("grant_other", side ? req0_ready : req1_ready, 1'b0);
        step();
        if (drop) begin
            if (side) req1_valid = 1'b0; else req0_valid = 1'b0;
        end else begin
            if (side) req1_addr = next_a; else req0_addr = next_a;
        end
        check("nonseq_trans", htrans, 2'b10);
        check("nonseq_addr", haddr, base);
        for (int k = 1; k < 4; k++) begin
            step();
            check("seq_trans", htrans, 2'b11);
            check("seq_addr", haddr, (base & ~32'hF) | ((base + 32'(4 * k)) & 32'hC));
        end
        step();
        check("drain_trans", htrans, 2'b00);
        check("drain_resp", resp0_valid | resp1_valid, 1'b0);
        step();
        check("resp_valid", side ? resp1_valid : resp0_valid, 1'b1);
        check("resp_err", side ? resp1_err : resp0_err, 1'b0);
        check("resp_other", side ? resp0_valid : resp1_valid, 1'b0);
        check("resp_line", side ? resp1_line : resp0_line, exp_line(a));
    endtask

    initial begin
        hrstn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 32'd0; req1_addr = 32'd0; hready = 1'b1; hresp = 1'b0;
        repeat (2) step();
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 32'd0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("rst_resp", {resp0_valid, resp0_err, resp1_valid, resp1_err}, 4'b0000);
        check("rst_line0", resp0_line, 128'd0);
        check("rst_line1", resp1_line, 128'd0);
        check("const_ctrl", {hburst, hsize, hwrite}, 7'b010_010_0);
        hrstn = 1'b1;
        step();

        // 1: single req0, critical word 0x1008
        req0_valid = 1'b1; req0_addr = 32'h0000_1008;
        burst(1'b0, 32'h0000_1008, 1'b1, 32'd0);
        check("t1_line_lit", resp0_line, 128'hAEE3100C_AEE71008_AEEB1004_AEEF1000);

        // 2: contention and alternation
        reset_dut();
        req0_valid = 1'b1; req0_addr = 32'h4000_0010;
        req1_valid = 1'b1; req1_addr = 32'h5000_0024;
        burst(1'b0, 32'h4000_0010, 1'b1, 32'd0);
        step();
        req0_valid = 1'b1; req0_addr = 32'h4000_0038;
        burst(1'b1, 32'h5000_0024, 1'b1, 32'd0);
        step();
        burst(1'b0, 32'h4000_0038, 1'b1, 32'd0);
        step();
        req0_valid = 1'b1; req0_addr = 32'h4000_0104;
        req1_valid = 1'b1; req1_addr = 32'h5000_0208;
        burst(1'b1, 32'h5000_0208, 1'b1, 32'd0);
        step();
        burst(1'b0, 32'h4000_0104, 1'b1, 32'd0);

        // 3: two-cycle stall on beat 2
        reset_dut();
        req0_valid = 1'b1; req0_addr = 32'h6000_0004;
        #1 check("t3_ready", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        check("t3_nonseq", {htrans, haddr}, {2'b10, 32'h6000_0004});
        step(); check("t3_b1", {htrans, haddr}, {2'b11, 32'h6000_0008});
        step(); check("t3_b2", {htrans, haddr}, {2'b11, 32'h6000_000C});
        hready = 1'b0;
        step(); check("t3_hold1", {htrans, haddr}, {2'b11, 32'h6000_000C});
        step(); check("t3_hold2", {htrans, haddr}, {2'b11, 32'h6000_000C});
        hready = 1'b1;
        step(); check("t3_b3", {htrans, haddr}, {2'b11, 32'h6000_0000});
        step(); check("t3_drain", {htrans, resp0_valid}, {2'b00, 1'b0});
        step(); check("t3_resp", resp0_valid, 1'b1);
        check("t3_line", resp0_line, exp_line(32'h6000_0004));

        // 4: error on beat-1 data phase of a req1 burst
        reset_dut();
        req0_valid = 1'b1; req0_addr = 32'h7000_0000;
        req1_valid = 1'b1; req1_addr = 32'h7100_0008;
        burst(1'b0, 32'h7000_0000, 1'b1, 32'd0);
        step();
        req0_valid = 1'b1; req0_addr = 32'h7000_0020;
        #1 check("t4_ready1", {req0_ready, req1_ready}, 2'b01);
        step(); req1_valid = 1'b0;
        check("t4_nonseq", {htrans, haddr}, {2'b10, 32'h7100_0008});
        step(); check("t4_b1", {htrans, haddr}, {2'b11, 32'h7100_000C});
        step(); check("t4_b2", {htrans, haddr}, {2'b11, 32'h7100_0000});
        hresp = 1'b1; hready = 1'b0;
        step(); check("t4_cancel", htrans, 2'b00);
        check("t4_noresp", resp1_valid, 1'b0);
        hready = 1'b1;
        step(); hresp = 1'b0;
        check("t4_idle", htrans, 2'b00);
        check("t4_resp", {resp1_valid, resp1_err, resp0_valid}, 3'b110);
        step(); check("t4_after", {htrans, resp1_valid}, {2'b00, 1'b0});
        req1_valid = 1'b1; req1_addr = 32'h7100_0030;
        #1 check("t4_ptr", {req0_ready, req1_ready}, 2'b10);
        burst(1'b0, 32'h7000_0020, 1'b1, 32'd0);
        step();
        burst(1'b1, 32'h7100_0030, 1'b1, 32'd0);

        // 5: reset mid-burst, then a fresh request
        reset_dut();
        req0_valid = 1'b1; req0_addr = 32'h8000_0008;
        #1 check("t5_ready", req0_ready, 1'b1);
        step(); step();
        check("t5_seq", htrans, 2'b11);
        hrstn = 1'b0; req0_addr = 32'h8000_0014;
        #1;
        check("t5_rst_trans", {htrans, haddr}, {2'b00, 32'd0});
        check("t5_rst_ready", {req0_ready, req1_ready}, 2'b00);
        check("t5_rst_resp", {resp0_valid, resp0_err, resp1_valid}, 3'b000);
        step();
        hrstn = 1'b1;
        burst(1'b0, 32'h8000_0014, 1'b1, 32'd0);

        // 6: req1 alone, three back-to-back bursts
        reset_dut();
        req1_valid = 1'b1; req1_addr = 32'h9000_000C;
        burst(1'b1, 32'h9000_000C, 1'b0, 32'h9000_0004);
        step();
        burst(1'b1, 32'h9000_0004, 1'b0, 32'h9000_0008);
        step();
        burst(1'b1, 32'h9000_0008, 1'b1, 32'd0);
        step();
        check("t6_quiet", {htrans, req1_ready}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
